// File: rtl/johnson_pkg.sv
// Shared constants and FSM state type for the Johnson counter sequencer.
//   JC_SIZE   : default index of the last ring stage
//   JC_N      : ring width (JC_SIZE+1)
//   JC_PHASES : number of distinct legal phases (2*JC_N)
//   JC_PW     : width of the phase index output
package johnson_pkg;
  localparam int JC_SIZE   = 7;
  localparam int JC_N      = JC_SIZE + 1;
  localparam int JC_PHASES = 2 * JC_N;
  localparam int JC_PW     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOME = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/johnson_step.sv
// Johnson ring register with load/step controls, legality check and phase decode.
// Ports:
//   clk, r       : clock, synchronous active-high reset
//   i_ld         : load i_ld_val into the ring (caller gates to IDLE)
//   i_ld_val     : seed value, [0:size]
//   i_step       : advance the ring one phase
//   o_out        : ring state, [0:size]
//   o_phase      : phase index decoded from o_out
//   o_illegal    : current ring value is not a Johnson pattern
//   o_zero       : ring is at home (all zeros)
//   o_next_zero  : the next step would land on home
module johnson_step
  import johnson_pkg::*;
#(
  parameter int size = JC_SIZE
) (
  input  logic             clk,
  input  logic             r,
  input  logic             i_ld,
  input  logic [0:size]    i_ld_val,
  input  logic             i_step,
  output logic [0:size]    o_out,
  output logic [JC_PW-1:0] o_phase,
  output logic             o_illegal,
  output logic             o_zero,
  output logic             o_next_zero
);
  logic [0:size] r_out;
  logic [0:size] w_next;
  int            w_k;     // popcount
  int            w_t;     // adjacent-bit transitions
  int            w_ph;

  assign w_next = {~r_out[size], r_out[0:size-1]};

  // A Johnson pattern has at most one boundary between runs of 1s and 0s.
  always_comb begin
    w_k = 0;
    w_t = 0;
    for (int i = 0; i <= size; i++) w_k = w_k + int'(r_out[i]);
    for (int i = 0; i < size; i++)  w_t = w_t + int'(r_out[i] ^ r_out[i+1]);
  end

  // Filling phases have out[0]=1 and phase=k; draining phases count down from 2n.
  always_comb begin
    w_ph = 0;
    if (r_out[0])      w_ph = w_k;
    else if (w_k != 0) w_ph = 2 * (size + 1) - w_k;
  end

  assign o_illegal   = (w_t > 1);
  assign o_zero      = (r_out == '0);
  assign o_next_zero = (w_next == '0);
  assign o_phase     = JC_PW'(w_ph);
  assign o_out       = r_out;

  // Illegal-pattern recovery overrides any load or step.
  always_ff @(posedge clk) begin
    if (r)              r_out <= '0;
    else if (o_illegal) r_out <= '0;
    else if (i_ld)      r_out <= i_ld_val;
    else if (i_step)    r_out <= w_next;
  end
endmodule

// File: rtl/johnson_sequencer.sv
// Run controller for a Johnson counter: one-shot or continuous runs, return to
// home before completion, sticky error on illegal ring patterns.
// Ports:
//   clk, r    : clock, synchronous active-high reset
//   start     : begin a run (IDLE only); mode/run_len sampled with it
//   run_len   : one-shot step count; 0 completes immediately
//   mode      : 0 one-shot, 1 continuous until stop
//   stop      : end a run (RUN only)
//   ld/ld_val : seed the ring (IDLE only, wins over start)
//   out/phase : ring state and decoded phase
//   busy      : RUN, HOME or DONE
//   done      : one-cycle completion pulse
//   err       : sticky illegal-pattern flag
module johnson_sequencer
  import johnson_pkg::*;
#(
  parameter int size = JC_SIZE
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [7:0]       run_len,
  input  logic             mode,
  input  logic             stop,
  input  logic             ld,
  input  logic [0:size]    ld_val,
  output logic [0:size]    out,
  output logic [JC_PW-1:0] phase,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t     r_state;
  logic [7:0] r_rem;
  logic       r_mode;
  logic       r_err;
  logic       w_ld;
  logic       w_step;
  logic       w_illegal;
  logic       w_zero;
  logic       w_next_zero;

  assign w_ld   = (r_state == ST_IDLE) && ld;
  // HOME steps only while away from zero; arriving at HOME already at zero skips stepping.
  assign w_step = (r_state == ST_RUN) || ((r_state == ST_HOME) && !w_zero);

  johnson_step #(.size(size)) u_step (
    .clk         (clk),
    .r           (r),
    .i_ld        (w_ld),
    .i_ld_val    (ld_val),
    .i_step      (w_step),
    .o_out       (out),
    .o_phase     (phase),
    .o_illegal   (w_illegal),
    .o_zero      (w_zero),
    .o_next_zero (w_next_zero)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= ST_IDLE;
      r_rem   <= 8'd0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_illegal) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!ld && start) begin
            r_err  <= 1'b0;
            r_mode <= mode;
            r_rem  <= run_len;
            if (!mode && run_len == 8'd0) r_state <= ST_DONE;
            else                          r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!r_mode) r_rem <= r_rem - 8'd1;
          if (stop || (!r_mode && r_rem == 8'd1)) r_state <= ST_HOME;
        end
        ST_HOME: begin
          if (w_zero || w_next_zero) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign err  = r_err;
endmodule

// File: tb/tb_johnson_sequencer.sv
module tb_johnson_sequencer;
  logic       clk = 1'b0;
  logic       r = 1'b0;
  logic       start = 1'b0;
  logic [7:0] run_len = 8'd0;
  logic       mode = 1'b0;
  logic       stop = 1'b0;
  logic       ld = 1'b0;
  logic [0:7] ld_val = 8'd0;
  logic [0:7] out;
  logic [3:0] phase;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [0:7] jtab [16];

  always #5 clk = ~clk;

  johnson_sequencer #(.size(7)) dut (
    .clk(clk), .r(r), .start(start), .run_len(run_len), .mode(mode),
    .stop(stop), .ld(ld), .ld_val(ld_val), .out(out), .phase(phase),
    .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; tick(); r = 1'b0;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %b exp 00000000", out); end
    checks++; if (phase !== 4'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
  endtask

  task automatic test_oneshot();
    mode = 1'b0; run_len = 8'd3; start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || out !== 8'h00) begin errors++; $display("FAIL os_e0 got busy %b out %b exp 1 00000000", busy, out); end
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++; if (out !== jtab[e % 16]) begin errors++; $display("FAIL os_out e%0d got %b exp %b", e, out, jtab[e % 16]); end
      checks++; if (phase !== 4'(e % 16)) begin errors++; $display("FAIL os_phase e%0d got %0d exp %0d", e, phase, e % 16); end
      checks++; if (done !== (e == 16) || busy !== 1'b1) begin errors++; $display("FAIL os_flags e%0d got done %b busy %b exp %b 1", e, done, busy, e == 16); end
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL os_end got done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_stop_cont();
    mode = 1'b1; run_len = 8'd1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    checks++; if (out !== 8'b11000000) begin errors++; $display("FAIL cs_pre got %b exp 11000000", out); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (out !== 8'b11100000 || busy !== 1'b1) begin errors++; $display("FAIL cs_stop got %b busy %b exp 11100000 1", out, busy); end
    for (int i = 1; i <= 13; i++) begin
      tick();
      checks++; if (out !== jtab[(3 + i) % 16] || done !== (i == 13)) begin
        errors++; $display("FAIL cs_home i%0d got %b done %b exp %b %b", i, out, done, jtab[(3 + i) % 16], i == 13);
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cs_end got busy %b done %b exp 0 0", busy, done); end
    mode = 1'b0;
  endtask

  task automatic test_ld_illegal();
    ld = 1'b1; ld_val = 8'b01000000; tick(); ld = 1'b0;
    checks++; if (out !== 8'b01000000 || err !== 1'b0) begin errors++; $display("FAIL il_load got %b err %b exp 01000000 0", out, err); end
    tick();
    checks++; if (out !== 8'h00 || err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL il_recover got %b err %b busy %b exp 00000000 1 0", out, err, busy); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL il_sticky got %b exp 1", err); end
    mode = 1'b0; run_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL il_clear got err %b done %b exp 0 1", err, done); end
    tick();
  endtask

  task automatic test_ld_run();
    logic [0:7] exp_seq [6];
    exp_seq[0] = 8'b00011111; exp_seq[1] = 8'b00001111; exp_seq[2] = 8'b00000111;
    exp_seq[3] = 8'b00000011; exp_seq[4] = 8'b00000001; exp_seq[5] = 8'b00000000;
    ld = 1'b1; ld_val = 8'b00111111; tick(); ld = 1'b0;
    checks++; if (out !== 8'b00111111 || phase !== 4'd10) begin errors++; $display("FAIL lr_load got %b ph %0d exp 00111111 10", out, phase); end
    mode = 1'b0; run_len = 8'd2; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out !== exp_seq[i] || done !== (i == 5)) begin
        errors++; $display("FAIL lr_step i%0d got %b done %b exp %b %b", i, out, done, exp_seq[i], i == 5);
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lr_end got busy %b exp 0", busy); end
  endtask

  task automatic test_misc();
    mode = 1'b0; run_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    checks++; if (done !== 1'b1 || out !== 8'h00) begin errors++; $display("FAIL z_done got done %b out %b exp 1 00000000", done, out); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL z_idle got done %b busy %b exp 0 0", done, busy); end
    // start while busy must not restart or disturb the run
    run_len = 8'd1; start = 1'b1; tick();
    run_len = 8'd0; tick(); start = 1'b0;
    checks++; if (out !== 8'b10000000 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL busy_start got %b busy %b done %b exp 10000000 1 0", out, busy, done); end
    for (int i = 0; i < 14; i++) tick();
    checks++; if (done !== 1'b0 || out !== 8'b00000001) begin errors++; $display("FAIL busy_pre got done %b out %b exp 0 00000001", done, out); end
    tick();
    checks++; if (done !== 1'b1 || out !== 8'h00) begin errors++; $display("FAIL busy_done got done %b out %b exp 1 00000000", done, out); end
    tick();
    // ld beats start
    ld = 1'b1; ld_val = 8'b11110000; run_len = 8'd5; start = 1'b1; tick(); ld = 1'b0; start = 1'b0;
    checks++; if (out !== 8'b11110000 || busy !== 1'b0) begin errors++; $display("FAIL ldstart got %b busy %b exp 11110000 0", out, busy); end
    tick();
    checks++; if (out !== 8'b11110000 || busy !== 1'b0) begin errors++; $display("FAIL ldstart_hold got %b busy %b exp 11110000 0", out, busy); end
    // stop in IDLE is ignored
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (out !== 8'b11110000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_stop got %b busy %b exp 11110000 0", out, busy); end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; run_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy %b exp 0", busy); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    ld = 1'b1; ld_val = 8'h00; tick(); ld = 1'b0;
    mode = 1'b1; run_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++; if (out !== 8'b11100000) begin errors++; $display("FAIL rm_pre got %b exp 11100000", out); end
    r = 1'b1; tick(); r = 1'b0;
    checks++; if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_abort got %b busy %b done %b exp 00000000 0 0", out, busy, done); end
    tick();
    checks++; if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_after got %b busy %b done %b exp 00000000 0 0", out, busy, done); end
    mode = 1'b0;
  endtask

  initial begin
    jtab[0]  = 8'b00000000; jtab[1]  = 8'b10000000; jtab[2]  = 8'b11000000; jtab[3]  = 8'b11100000;
    jtab[4]  = 8'b11110000; jtab[5]  = 8'b11111000; jtab[6]  = 8'b11111100; jtab[7]  = 8'b11111110;
    jtab[8]  = 8'b11111111; jtab[9]  = 8'b01111111; jtab[10] = 8'b00111111; jtab[11] = 8'b00011111;
    jtab[12] = 8'b00001111; jtab[13] = 8'b00000111; jtab[14] = 8'b00000011; jtab[15] = 8'b00000001;
    test_reset();
    test_oneshot();
    test_stop_cont();
    test_ld_illegal();
    test_ld_run();
    test_misc();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
